axis_acq_sequencer: RTL and testbench
=====================================

Name: axis_acq_sequencer

Overview:
- Frame-based acquisition controller that sits directly downstream of axis_throttler and drives its log_throttle input.
- On a start request it latches the decimation setting and frame length, then discards a settle window so the throttler phase realigns.
- It then passes exactly `length` decimated samples to the DMA-side stream, marks the final one with tlast, and returns to idle.
- Abort and status outputs let the register bank sequence repeated captures.

Parameters:
AXIS_TDATA_WIDTH, 32, stream data width
LENGTH_WIDTH, 16, width of frame length and sample counter
SETTLE_CYCLES, 64, cycles of upstream discard after each accepted start (min 1)

Ports:
aclk  in  1  system clock
aresetn  in  1  reset, synchronous, active-low
start  in  1  capture request, level-sampled each cycle
abort  in  1  cancel current capture, level-sampled
log_throttle_req  in  5  requested decimation exponent
length  in  LENGTH_WIDTH  samples per frame
log_throttle  out  5  registered decimation exponent to axis_throttler
busy  out  1  high in SETTLE and RUN
done  out  1  one-cycle pulse on frame completion
aborted  out  1  one-cycle pulse on abort taking effect
sample_count  out  LENGTH_WIDTH  handshakes accepted in current frame
S_AXIS_tready  out  1  upstream (throttler output) ready
S_AXIS_tvalid  in  1  upstream valid
S_AXIS_tdata  in  AXIS_TDATA_WIDTH  upstream data
M_AXIS_tready  in  1  downstream ready
M_AXIS_tvalid  out  1  downstream valid
M_AXIS_tdata  out  AXIS_TDATA_WIDTH  downstream data, = S_AXIS_tdata
M_AXIS_tlast  out  1  last sample of frame

Behaviour:
- Single clock aclk. Reset is synchronous, active-low on aresetn. All state registers update only on posedge aclk.
- Reset values: state IDLE, log_throttle 0, busy 0, done 0, aborted 0, sample_count 0, length_q 0, settle counter 0. While aresetn low, S_AXIS_tready = 0 and M_AXIS_tvalid = 0.
- States: IDLE, SETTLE, RUN, DONE.
- IDLE:
  - S_AXIS_tready = 1 (upstream drained and discarded); M_AXIS_tvalid = 0.
  - start = 1 with length != 0 is accepted: latch length_q <= length, log_throttle <= log_throttle_req, settle counter <= SETTLE_CYCLES-1, sample_count <= 0; go to SETTLE.
  - start with length == 0 is ignored, state stays IDLE.
- SETTLE:
  - S_AXIS_tready = 1, M_AXIS_tvalid = 0, data discarded. Counter decrements each cycle.
  - Counter == 0 → RUN. Exactly SETTLE_CYCLES cycles are spent in SETTLE.
- RUN:
  - Pass-through: S_AXIS_tready = M_AXIS_tready; M_AXIS_tvalid = S_AXIS_tvalid.
  - Handshake = S_AXIS_tvalid & M_AXIS_tready; it increments sample_count.
  - M_AXIS_tlast = (sample_count == length_q-1), combinational and qualified only in RUN.
  - Handshake with tlast → DONE; sample_count then reads length_q.
- DONE: tready = 1 (discard), tvalid = 0, done = 1 for this single cycle; → IDLE.
- busy = (state == SETTLE or RUN), registered-state decode.
- log_throttle changes only on an accepted start; it is stable throughout SETTLE/RUN/DONE.
- start outside IDLE: ignored; no queuing.
- abort:
  - In SETTLE or RUN: → IDLE next cycle, aborted pulses 1 in that IDLE cycle, done stays 0.
  - A handshake occurring in the abort cycle still completes and counts; M_AXIS_tlast is not forced.
  - abort in IDLE or DONE has no effect (DONE still completes).
  - abort and start together in IDLE: start wins.
- sample_count holds its final value in IDLE until the next accepted start.
- Arithmetic: sample_count and length_q are LENGTH_WIDTH unsigned. length = 2^LENGTH_WIDTH-1 is legal; there is no wrap because the frame ends first.
- Latency: zero-cycle combinational passthrough in RUN; no data register in the block.

Decomposition:
- Package acq_pkg: typedef enum logic [1:0] acq_state_t {IDLE, SETTLE, RUN, DONE}; constant LOG_THROTTLE_W = 5.
- Single sub-module acq_settle_timer: down-counter with load and a zero flag.
- axis_throttler is instantiated alongside, not inside.

Test Plan:
- Reset, then length=4, log_throttle_req=2, start pulse, M_AXIS_tready=1, S_AXIS_tvalid=1 continuous:
  - log_throttle=2 the cycle after start.
  - busy high.
  - After exactly 64 SETTLE cycles, 4 beats are forwarded; tlast on beat 4 only.
  - done pulses once; sample_count=4.
- Backpressure: same frame with M_AXIS_tready toggling 1/0 each cycle:
  - no beat lost or duplicated (data is a counting pattern);
  - S_AXIS_tready mirrors M_AXIS_tready in RUN;
  - tlast is held stable while stalled.
- Abort after 2 of 8 beats:
  - IDLE next cycle, aborted=1 for one cycle, done never asserted;
  - no tlast emitted; sample_count=2 (3 if abort coincides with a handshake).
- Control boundaries:
  - start with length=0 → stays IDLE, log_throttle unchanged.
  - start during RUN with log_throttle_req=7 → ignored, log_throttle unchanged.
  - length=1 → single beat with tlast.
- Reset asserted mid-RUN: the cycle after, state IDLE, busy=0, log_throttle=0, M_AXIS_tvalid=0; S_AXIS_tready=0 while aresetn low.

Source files
------------

// File: rtl/acq_pkg.sv
// -----------------------------------------------------------------------------
// acq_pkg
// Shared types and constants for the frame acquisition sequencer.
//   acq_state_t    : sequencer state encoding (IDLE, SETTLE, RUN, DONE)
//   LOG_THROTTLE_W : width of the decimation exponent driven to axis_throttler
// -----------------------------------------------------------------------------
package acq_pkg;

  localparam int LOG_THROTTLE_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } acq_state_t;

endpackage

// File: rtl/acq_settle_timer.sv
// -----------------------------------------------------------------------------
// acq_settle_timer
// Loadable down-counter that times the post-start discard window.
// Ports:
//   clk      : clock
//   rst_n    : synchronous active-low reset (counter clears to zero)
//   load     : load load_val (takes priority over dec)
//   load_val : value to load
//   dec      : decrement by one; saturates at zero
//   zero     : counter currently reads zero
// -----------------------------------------------------------------------------
module acq_settle_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/axis_acq_sequencer.sv
// -----------------------------------------------------------------------------
// axis_acq_sequencer
// Frame-based acquisition controller placed downstream of axis_throttler.
// A start with non-zero length latches the decimation exponent and frame
// length, discards SETTLE_CYCLES cycles of upstream data so the throttler
// phase realigns, then forwards exactly `length` samples with tlast on the
// final one.
// Ports:
//   aclk, aresetn        : clock, synchronous active-low reset
//   start, abort         : level-sampled capture request / cancel
//   log_throttle_req     : requested decimation exponent
//   length               : samples per frame
//   log_throttle         : registered exponent to axis_throttler
//   busy, done, aborted  : status (busy in SETTLE/RUN, one-cycle pulses)
//   sample_count         : handshakes accepted in the current frame
//   S_AXIS_*             : upstream stream (throttler output)
//   M_AXIS_*             : downstream stream (DMA side), zero-latency passthrough
// -----------------------------------------------------------------------------
module axis_acq_sequencer
  import acq_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int LENGTH_WIDTH     = 16,
  parameter int SETTLE_CYCLES    = 64
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        start,
  input  logic                        abort,
  input  logic [LOG_THROTTLE_W-1:0]   log_throttle_req,
  input  logic [LENGTH_WIDTH-1:0]     length,
  output logic [LOG_THROTTLE_W-1:0]   log_throttle,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted,
  output logic [LENGTH_WIDTH-1:0]     sample_count,
  output logic                        S_AXIS_tready,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tlast
);

  // Extra bit keeps the width non-zero when SETTLE_CYCLES is 1.
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  acq_state_t                state_q, state_d;
  logic [LOG_THROTTLE_W-1:0] log_throttle_q, log_throttle_d;
  logic [LENGTH_WIDTH-1:0]   length_q, length_d;
  logic [LENGTH_WIDTH-1:0]   sample_count_q, sample_count_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      aborted_q, aborted_d;

  logic timer_load;
  logic timer_dec;
  logic timer_zero;
  logic s_tready;
  logic m_tvalid;
  logic m_tlast;
  logic handshake;

  acq_settle_timer #(
    .CNT_W (SETTLE_W)
  ) u_settle_timer (
    .clk      (aclk),
    .rst_n    (aresetn),
    .load     (timer_load),
    .load_val (SETTLE_W'(SETTLE_CYCLES - 1)),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // Next-state, stream steering and status pulse generation.
  always_comb begin
    state_d        = state_q;
    log_throttle_d = log_throttle_q;
    length_d       = length_q;
    sample_count_d = sample_count_q;
    aborted_d      = 1'b0;
    timer_load     = 1'b0;
    timer_dec      = 1'b0;
    s_tready       = 1'b0;
    m_tvalid       = 1'b0;
    m_tlast        = 1'b0;
    handshake      = 1'b0;

    case (state_q)
      IDLE: begin
        s_tready = 1'b1;
        // abort is ignored here, so start wins when both are high.
        if (start && (length != {LENGTH_WIDTH{1'b0}})) begin
          length_d       = length;
          log_throttle_d = log_throttle_req;
          sample_count_d = {LENGTH_WIDTH{1'b0}};
          timer_load     = 1'b1;
          state_d        = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end

      SETTLE: begin
        s_tready  = 1'b1;
        timer_dec = 1'b1;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (timer_zero) begin
          state_d = RUN;
        end else begin
          state_d = SETTLE;
        end
      end

      RUN: begin
        s_tready  = M_AXIS_tready;
        m_tvalid  = S_AXIS_tvalid;
        m_tlast   = (sample_count_q == (length_q - LENGTH_WIDTH'(1)));
        handshake = S_AXIS_tvalid & M_AXIS_tready;
        if (handshake) begin
          sample_count_d = sample_count_q + LENGTH_WIDTH'(1);
        end else begin
          sample_count_d = sample_count_q;
        end
        // Abort takes priority; a beat accepted in the same cycle still counts.
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (handshake && m_tlast) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end

      DONE: begin
        s_tready = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SETTLE) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Control and status registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q        <= IDLE;
      log_throttle_q <= {LOG_THROTTLE_W{1'b0}};
      length_q       <= {LENGTH_WIDTH{1'b0}};
      sample_count_q <= {LENGTH_WIDTH{1'b0}};
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      log_throttle_q <= log_throttle_d;
      length_q       <= length_d;
      sample_count_q <= sample_count_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
    end
  end

  // Handshake outputs are forced idle while reset is held.
  assign S_AXIS_tready = aresetn & s_tready;
  assign M_AXIS_tvalid = aresetn & m_tvalid;
  assign M_AXIS_tdata  = S_AXIS_tdata;
  assign M_AXIS_tlast  = m_tlast;
  assign log_throttle  = log_throttle_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign sample_count  = sample_count_q;

endmodule

// File: tb/tb_axis_acq_sequencer.sv
module tb_axis_acq_sequencer;

  localparam int DW     = 32;
  localparam int LW     = 16;
  localparam int SETTLE = 64;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          start;
  logic          abort;
  logic [4:0]    log_throttle_req;
  logic [LW-1:0] length;
  logic [4:0]    log_throttle;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [LW-1:0] sample_count;
  logic          S_AXIS_tready;
  logic          S_AXIS_tvalid;
  logic [DW-1:0] S_AXIS_tdata;
  logic          M_AXIS_tready;
  logic          M_AXIS_tvalid;
  logic [DW-1:0] M_AXIS_tdata;
  logic          M_AXIS_tlast;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [4:0] last_lt  = 5'd0;

  always #5 aclk = ~aclk;

  axis_acq_sequencer #(
    .AXIS_TDATA_WIDTH (DW),
    .LENGTH_WIDTH     (LW),
    .SETTLE_CYCLES    (SETTLE)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .start            (start),
    .abort            (abort),
    .log_throttle_req (log_throttle_req),
    .length           (length),
    .log_throttle     (log_throttle),
    .busy             (busy),
    .done             (done),
    .aborted          (aborted),
    .sample_count     (sample_count),
    .S_AXIS_tready    (S_AXIS_tready),
    .S_AXIS_tvalid    (S_AXIS_tvalid),
    .S_AXIS_tdata     (S_AXIS_tdata),
    .M_AXIS_tready    (M_AXIS_tready),
    .M_AXIS_tvalid    (M_AXIS_tvalid),
    .M_AXIS_tdata     (M_AXIS_tdata),
    .M_AXIS_tlast     (M_AXIS_tlast)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Reference model: a frame is SETTLE cycles of discard after the start
  // cycle, then passthrough until `len` beats are accepted (tlast on beat
  // len) or abort is seen; status is checked one and two cycles later.
  task automatic run_frame(input int len, input logic [4:0] ltr, input int rdy_mode,
                           input int vld_mode, input int abort_at, input bit abort_with_start,
                           input string tag);
    int         beats;
    int         cyc;
    int         budget;
    bit         fin;
    bit         abort_seen;
    bit         hs;
    logic       exp_last;
    logic [DW-1:0] data;

    start = 1'b1; length = LW'(len); log_throttle_req = ltr; abort = abort_with_start;
    S_AXIS_tvalid = 1'b1; M_AXIS_tready = 1'b1; S_AXIS_tdata = 32'h0;
    @(negedge aclk);
    n_checks++; if (S_AXIS_tready !== 1'b1) begin n_fail++; $display("FAIL %s idle_tready got=%0d exp=1", tag, S_AXIS_tready); end
    step();

    for (int i = 0; i < SETTLE; i++) begin
      start = 1'(($urandom % 2)); abort = 1'b0; log_throttle_req = 5'd7; length = LW'($urandom);
      S_AXIS_tvalid = 1'b1; S_AXIS_tdata = $urandom; M_AXIS_tready = 1'(($urandom % 2));
      @(negedge aclk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s settle_busy[%0d] got=%0d exp=1", tag, i, busy); end
      n_checks++; if (log_throttle !== ltr) begin n_fail++; $display("FAIL %s settle_log_throttle[%0d] got=%0d exp=%0d", tag, i, log_throttle, ltr); end
      n_checks++; if (S_AXIS_tready !== 1'b1 || M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL %s settle_discard[%0d] got tready=%0d tvalid=%0d exp 1/0", tag, i, S_AXIS_tready, M_AXIS_tvalid); end
      if (i == 0) begin
        n_checks++; if (sample_count !== '0) begin n_fail++; $display("FAIL %s settle_count got=%0d exp=0", tag, sample_count); end
      end
      step();
    end

    beats = 0; cyc = 0; fin = 1'b0; abort_seen = 1'b0; data = 32'h0000_1000;
    budget = len * 8 + 50;
    while (!fin && cyc < budget) begin
      case (rdy_mode)
        0: M_AXIS_tready = 1'b1;
        1: M_AXIS_tready = (cyc % 2 == 0);
        default: M_AXIS_tready = 1'(($urandom % 2));
      endcase
      S_AXIS_tvalid = (vld_mode == 0 || cyc == 0) ? 1'b1 : (($urandom % 4) != 0);
      S_AXIS_tdata  = data;
      abort = (abort_at >= 0 && beats == abort_at);
      start = 1'(($urandom % 2)); log_throttle_req = 5'd7; length = LW'($urandom);
      exp_last = (beats == len - 1);
      @(negedge aclk);
      n_checks++; if (M_AXIS_tvalid !== S_AXIS_tvalid) begin n_fail++; $display("FAIL %s run_tvalid[%0d] got=%0d exp=%0d", tag, cyc, M_AXIS_tvalid, S_AXIS_tvalid); end
      n_checks++; if (S_AXIS_tready !== M_AXIS_tready) begin n_fail++; $display("FAIL %s run_tready[%0d] got=%0d exp=%0d", tag, cyc, S_AXIS_tready, M_AXIS_tready); end
      n_checks++; if (M_AXIS_tdata !== data) begin n_fail++; $display("FAIL %s run_tdata[%0d] got=%0h exp=%0h", tag, cyc, M_AXIS_tdata, data); end
      n_checks++; if (M_AXIS_tlast !== exp_last) begin n_fail++; $display("FAIL %s run_tlast[%0d] got=%0d exp=%0d", tag, cyc, M_AXIS_tlast, exp_last); end
      n_checks++; if (sample_count !== LW'(beats)) begin n_fail++; $display("FAIL %s run_count[%0d] got=%0d exp=%0d", tag, cyc, sample_count, beats); end
      n_checks++; if (busy !== 1'b1 || done !== 1'b0 || log_throttle !== ltr) begin n_fail++; $display("FAIL %s run_status[%0d] got busy=%0d done=%0d lt=%0d exp 1/0/%0d", tag, cyc, busy, done, log_throttle, ltr); end
      hs = S_AXIS_tvalid & M_AXIS_tready;
      if (hs) begin
        beats++;
        data++;
      end
      if (abort) begin
        fin = 1'b1; abort_seen = 1'b1;
      end else if (hs && exp_last) begin
        fin = 1'b1;
      end
      step();
      cyc++;
    end
    n_checks++; if (!fin) begin n_fail++; $display("FAIL %s frame_timeout got beats=%0d exp=%0d within %0d cycles", tag, beats, len, budget); end

    start = 1'b0; abort = 1'b0; M_AXIS_tready = 1'b1; S_AXIS_tvalid = 1'b1;
    @(negedge aclk);
    n_checks++; if (done !== !abort_seen || aborted !== abort_seen) begin n_fail++; $display("FAIL %s end_pulse got done=%0d aborted=%0d exp %0d/%0d", tag, done, aborted, !abort_seen, abort_seen); end
    n_checks++; if (busy !== 1'b0 || M_AXIS_tvalid !== 1'b0 || S_AXIS_tready !== 1'b1) begin n_fail++; $display("FAIL %s end_stream got busy=%0d tvalid=%0d tready=%0d exp 0/0/1", tag, busy, M_AXIS_tvalid, S_AXIS_tready); end
    n_checks++; if (sample_count !== LW'(beats)) begin n_fail++; $display("FAIL %s end_count got=%0d exp=%0d", tag, sample_count, beats); end
    n_checks++; if (log_throttle !== ltr) begin n_fail++; $display("FAIL %s end_log_throttle got=%0d exp=%0d", tag, log_throttle, ltr); end
    step();
    @(negedge aclk);
    n_checks++; if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s idle_status got done=%0d aborted=%0d busy=%0d exp 0/0/0", tag, done, aborted, busy); end
    n_checks++; if (sample_count !== LW'(beats)) begin n_fail++; $display("FAIL %s idle_count_hold got=%0d exp=%0d", tag, sample_count, beats); end
    step();
    last_lt = ltr;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; start = 1'b0; abort = 1'b0; log_throttle_req = 5'd0; length = '0;
    S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 32'h0; M_AXIS_tready = 1'b1;
    repeat (3) step();
    @(negedge aclk);
    n_checks++; if (S_AXIS_tready !== 1'b0 || M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_stream got tready=%0d tvalid=%0d exp 0/0", S_AXIS_tready, M_AXIS_tvalid); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin n_fail++; $display("FAIL reset_status got busy=%0d done=%0d aborted=%0d exp 0/0/0", busy, done, aborted); end
    n_checks++; if (log_throttle !== 5'd0 || sample_count !== '0) begin n_fail++; $display("FAIL reset_regs got lt=%0d count=%0d exp 0/0", log_throttle, sample_count); end
    step();
    aresetn = 1'b1;
    step();
    @(negedge aclk);
    n_checks++; if (S_AXIS_tready !== 1'b1 || M_AXIS_tvalid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle got tready=%0d tvalid=%0d busy=%0d exp 1/0/0", S_AXIS_tready, M_AXIS_tvalid, busy); end
    step();
    last_lt = 5'd0;
  endtask

  task automatic test_basic();
    run_frame(4, 5'd2, 0, 0, -1, 1'b0, "basic");
  endtask

  task automatic test_backpressure();
    run_frame(4, 5'd2, 1, 0, -1, 1'b0, "bp_toggle");
    run_frame(6, 5'd3, 1, 1, -1, 1'b0, "bp_toggle_gaps");
  endtask

  task automatic test_abort();
    run_frame(8, 5'd5, 0, 0, 2, 1'b0, "abort_hs");
    run_frame(8, 5'd4, 2, 1, 3, 1'b0, "abort_rand");
  endtask

  task automatic test_boundaries();
    start = 1'b1; length = '0; log_throttle_req = 5'd9; abort = 1'b0;
    step();
    start = 1'b0;
    @(negedge aclk);
    n_checks++; if (busy !== 1'b0 || log_throttle !== last_lt) begin n_fail++; $display("FAIL len0_ignored got busy=%0d lt=%0d exp 0/%0d", busy, log_throttle, last_lt); end
    n_checks++; if (S_AXIS_tready !== 1'b1 || M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL len0_idle got tready=%0d tvalid=%0d exp 1/0", S_AXIS_tready, M_AXIS_tvalid); end
    step();
    run_frame(1, 5'd6, 0, 0, -1, 1'b1, "len1_start_abort");
    run_frame(2, 5'd1, 1, 0, -1, 1'b0, "len2");
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int len;
      int ab;
      len = 1 + int'($urandom_range(24));
      ab  = (($urandom % 3) == 0) ? int'($urandom_range(len + 2)) : -1;
      run_frame(len, 5'($urandom_range(6)), 2, 1, ab, 1'(($urandom % 2)), "random");
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; length = 16'd8; log_throttle_req = 5'd3; abort = 1'b0;
    S_AXIS_tvalid = 1'b1; M_AXIS_tready = 1'b1;
    step();
    start = 1'b0;
    repeat (SETTLE + 2) step();
    @(negedge aclk);
    n_checks++; if (busy !== 1'b1 || M_AXIS_tvalid !== 1'b1) begin n_fail++; $display("FAIL midrun_active got busy=%0d tvalid=%0d exp 1/1", busy, M_AXIS_tvalid); end
    step();
    aresetn = 1'b0;
    @(negedge aclk);
    n_checks++; if (S_AXIS_tready !== 1'b0 || M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_stream got tready=%0d tvalid=%0d exp 0/0", S_AXIS_tready, M_AXIS_tvalid); end
    step();
    @(negedge aclk);
    n_checks++; if (busy !== 1'b0 || log_throttle !== 5'd0 || sample_count !== '0) begin n_fail++; $display("FAIL midrun_rst_regs got busy=%0d lt=%0d count=%0d exp 0/0/0", busy, log_throttle, sample_count); end
    n_checks++; if (M_AXIS_tvalid !== 1'b0 || S_AXIS_tready !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_held got tvalid=%0d tready=%0d exp 0/0", M_AXIS_tvalid, S_AXIS_tready); end
    aresetn = 1'b1;
    step();
    @(negedge aclk);
    n_checks++; if (S_AXIS_tready !== 1'b1 || M_AXIS_tvalid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrun_idle got tready=%0d tvalid=%0d busy=%0d exp 1/0/0", S_AXIS_tready, M_AXIS_tvalid, busy); end
    step();
    last_lt = 5'd0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_boundaries();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
